// File: rtl/fetch_stage_pkg.sv
// Shared constants for the MIPS instruction-fetch stage: state encoding, reset PC,
// PC step, bubble NOP word and the fetch-range helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ERROR  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // Word-aligned and within the words above base; addresses below base wrap large.
  function automatic logic fetchAddrOk(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] words);
    logic [31:0] offset;
    offset = (addr - base) >> 2;
    return (addr[1:0] == 2'b00) && (offset < words);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Decode-side and instruction-memory signals of the fetch stage, bundled with
// master (decode/memory side) and slave (fetch stage) views.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        halt;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] instructionD;
  logic [31:0] pcD;
  logic        bubbleD;
  logic        halted;
  logic [31:0] fetchCount;
  logic        fetchError;

  modport master (
    output stall, redirect, redirectTarget, halt, imemData,
    input  imemAddr, instructionD, pcD, bubbleD, halted, fetchCount, fetchError
  );

  modport slave (
    input  stall, redirect, redirectTarget, halt, imemData,
    output imemAddr, instructionD, pcD, bubbleD, halted, fetchCount, fetchError
  );
endinterface

// File: rtl/fetch_stage_ifid_register.sv
// IF/ID pipeline latch: bubble insert overrides hold, hold overrides load.
module ifid_register
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        bubble_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        bubble_q, bubble_d;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    bubble_d = bubble_q;
    if (bubble_i) begin
      instr_d  = NOP_WORD;
      pc_d     = '0;
      bubble_d = 1'b1;
    end else if (load_i && !hold_i) begin
      instr_d  = instr_i;
      pc_d     = pc_i;
      bubble_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q  <= NOP_WORD;
      pc_q     <= '0;
      bubble_q <= 1'b1;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
    end
  end

  assign instr_o  = instr_q;
  assign pc_o     = pc_q;
  assign bubble_o = bubble_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, run/halt FSM and fetch counter feeding the IF/ID latch.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned or out-of-range fetch addresses.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  nextPc;
  logic         ifLoad, ifHold, ifBubble;
  logic         err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // A redirect under stall is dropped; decode re-asserts it while the branch sits in D.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    err_d    = err_q;
    ifLoad   = 1'b0;
    ifHold   = 1'b0;
    ifBubble = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    nextPc   = bus.redirect ? bus.redirectTarget : (pc_q + PC_STEP);
`else
    nextPc   = bus.redirect ? (bus.redirectTarget & ~32'h3) : (pc_q + PC_STEP);
`endif
    case (state_q)
      RUN: begin
        if (bus.halt) begin
          state_d  = HALTED;
          ifBubble = 1'b1;
        end else if (bus.stall) begin
          ifHold = 1'b1;
        end else begin
          pc_d = nextPc;
`ifdef FETCH_ALIGN_CHECK_EN
          if (!fetchAddrOk(nextPc, RESET_PC, 32'(IMEM_WORDS))) begin
            state_d  = ERROR;
            err_d    = 1'b1;
            ifBubble = 1'b1;
          end else begin
            ifLoad  = 1'b1;
            count_d = count_q + 32'd1;
          end
`else
          ifLoad  = 1'b1;
          count_d = count_q + 32'd1;
`endif
        end
      end
      default: ifBubble = 1'b1;
    endcase
  end

  ifid_register u_ifid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (ifLoad),
    .hold_i   (ifHold),
    .bubble_i (ifBubble),
    .instr_i  (bus.imemData),
    .pc_i     (pc_q),
    .instr_o  (bus.instructionD),
    .pc_o     (bus.pcD),
    .bubble_o (bus.bubbleD)
  );

  assign bus.imemAddr   = pc_q;
  assign bus.halted     = (state_q != RUN);
  assign bus.fetchCount = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fetchError = err_q;
`else
  assign bus.fetchError = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of vectors plus hand-written corner sequences,
// each expected result queued when driven and compared one cycle later.
module tb_fetch_stage;

  typedef struct {
    logic        rstN;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        halt;
    logic [31:0] expAddr;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expBubble;
    logic        expHalted;
    logic [31:0] expCount;
    logic        expErr;
  } vec_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t table_v[10];

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_3000), .IMEM_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h8BAD_F00D;
  endfunction

  assign bus.imemData = memWord(bus.imemAddr);

  function automatic vec_t mk(input logic rstN, input logic stall, input logic redirect,
                              input logic [31:0] target, input logic halt,
                              input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pcd, input logic bub, input logic hlt,
                              input logic [31:0] cnt, input logic ferr);
    vec_t v;
    v.rstN = rstN; v.stall = stall; v.redirect = redirect; v.target = target; v.halt = halt;
    v.expAddr = addr; v.expInstr = instr; v.expPc = pcd; v.expBubble = bub;
    v.expHalted = hlt; v.expCount = cnt; v.expErr = ferr;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected a pending vector");
    end else begin
      e = sb.pop_front();
      cmp("imemAddr", bus.imemAddr, e.expAddr);
      cmp("bubbleD", 32'(bus.bubbleD), 32'(e.expBubble));
      cmp("halted", 32'(bus.halted), 32'(e.expHalted));
      cmp("fetchCount", bus.fetchCount, e.expCount);
      cmp("fetchError", 32'(bus.fetchError), 32'(e.expErr));
      if (!e.expBubble || !e.rstN) begin
        cmp("instructionD", bus.instructionD, e.expInstr);
        cmp("pcD", bus.pcD, e.expPc);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset              = v.rstN;
    bus.stall          = v.stall;
    bus.redirect       = v.redirect;
    bus.redirectTarget = v.target;
    bus.halt           = v.halt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirectTarget = '0;
    bus.halt = 1'b0;

    table_v[0] = mk(1,0,0,0,0, 32'h3004, memWord(32'h3000), 32'h3000, 0,0, 1, 0);
    table_v[1] = mk(1,0,0,0,0, 32'h3008, memWord(32'h3004), 32'h3004, 0,0, 2, 0);
    table_v[2] = mk(1,1,0,0,0, 32'h3008, memWord(32'h3004), 32'h3004, 0,0, 2, 0);
    table_v[3] = mk(1,1,0,0,0, 32'h3008, memWord(32'h3004), 32'h3004, 0,0, 2, 0);
    table_v[4] = mk(1,1,1,32'h3100,0, 32'h3008, memWord(32'h3004), 32'h3004, 0,0, 2, 0);
    table_v[5] = mk(1,0,0,0,0, 32'h300C, memWord(32'h3008), 32'h3008, 0,0, 3, 0);
    table_v[6] = mk(1,0,0,0,0, 32'h3010, memWord(32'h300C), 32'h300C, 0,0, 4, 0);
    table_v[7] = mk(1,0,1,32'h3040,0, 32'h3040, memWord(32'h3010), 32'h3010, 0,0, 5, 0);
    table_v[8] = mk(1,0,0,0,0, 32'h3044, memWord(32'h3040), 32'h3040, 0,0, 6, 0);
    table_v[9] = mk(1,0,0,0,0, 32'h3048, memWord(32'h3044), 32'h3044, 0,0, 7, 0);

    $display("[TB] reset phase");
    applyStimulus(mk(0,0,0,0,0, 32'h3000, 32'h0, 32'h0, 1,0, 0, 0));
    applyStimulus(mk(0,1,1,32'h3100,1, 32'h3000, 32'h0, 32'h0, 1,0, 0, 0));

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) applyStimulus(table_v[i]);

    $display("[TB] halt while stalled");
    applyStimulus(mk(1,1,0,0,1, 32'h3048, 32'h0, 32'h0, 1,1, 7, 0));
    for (int i = 0; i < 10; i++)
      applyStimulus(mk(1, i[0], i[1], 32'h3100, i[2], 32'h3048, 32'h0, 32'h0, 1,1, 7, 0));
    applyStimulus(mk(0,0,0,0,0, 32'h3000, 32'h0, 32'h0, 1,0, 0, 0));

    $display("[TB] misaligned and out-of-range redirects");
    applyStimulus(mk(1,0,0,0,0, 32'h3004, memWord(32'h3000), 32'h3000, 0,0, 1, 0));
`ifdef FETCH_ALIGN_CHECK_EN
    applyStimulus(mk(1,0,1,32'h3042,0, 32'h3042, 32'h0, 32'h0, 1,1, 1, 1));
    applyStimulus(mk(1,0,0,0,0, 32'h3042, 32'h0, 32'h0, 1,1, 1, 1));
    applyStimulus(mk(0,0,0,0,0, 32'h3000, 32'h0, 32'h0, 1,0, 0, 0));
    applyStimulus(mk(1,0,0,0,0, 32'h3004, memWord(32'h3000), 32'h3000, 0,0, 1, 0));
    applyStimulus(mk(1,0,1,32'h4000,0, 32'h4000, 32'h0, 32'h0, 1,1, 1, 1));
    applyStimulus(mk(1,1,1,32'h3000,0, 32'h4000, 32'h0, 32'h0, 1,1, 1, 1));
`else
    applyStimulus(mk(1,0,1,32'h3042,0, 32'h3040, memWord(32'h3004), 32'h3004, 0,0, 2, 0));
    applyStimulus(mk(1,0,0,0,0, 32'h3044, memWord(32'h3040), 32'h3040, 0,0, 3, 0));
    applyStimulus(mk(1,0,1,32'h4000,0, 32'h4000, memWord(32'h3044), 32'h3044, 0,0, 4, 0));
    applyStimulus(mk(1,0,0,0,0, 32'h4004, memWord(32'h4000), 32'h4000, 0,0, 5, 0));
    applyStimulus(mk(1,0,1,32'hFFFF_FFFC,0, 32'hFFFF_FFFC, memWord(32'h4004), 32'h4004, 0,0, 6, 0));
    applyStimulus(mk(1,0,0,0,0, 32'h0, memWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0,0, 7, 0));
`endif

    $display("[TB] reset during stall and redirect");
    applyStimulus(mk(0,0,0,0,0, 32'h3000, 32'h0, 32'h0, 1,0, 0, 0));
    applyStimulus(mk(1,0,0,0,0, 32'h3004, memWord(32'h3000), 32'h3000, 0,0, 1, 0));
    applyStimulus(mk(0,1,1,32'h3100,0, 32'h3000, 32'h0, 32'h0, 1,0, 0, 0));
    applyStimulus(mk(1,0,1,32'h3080,0, 32'h3080, memWord(32'h3000), 32'h3000, 0,0, 1, 0));
    applyStimulus(mk(1,0,0,0,0, 32'h3084, memWord(32'h3080), 32'h3080, 0,0, 2, 0));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter and drives the instruction-memory read port. Applies stall, redirect and halt requests from the decode stage. Registers the fetched word into the IF/ID latch that feeds the decode-stage Controller, including its `bubble` input. Uses MIPS branch-delay-slot semantics, so a redirect never flushes the slot instruction.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset
- IMEM_WORDS, 1024, instruction memory depth in words; sets the legal fetch range
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- redirect  in  1  decode stage: taken branch or absolute jump
- redirectTarget  in  32  next fetch address when redirect=1
- halt  in  1  decode stage holds syscall (Controller `bye`)
- imemAddr  out  32  current PC (combinational from PC register)
- imemData  in  32  instruction word at imemAddr, same cycle
- instructionD  out  32  IF/ID instruction
- pcD  out  32  IF/ID PC of instructionD
- bubbleD  out  1  IF/ID contents invalid
- halted  out  1  fetch permanently stopped
- fetchCount  out  32  number of instructions latched into IF/ID as valid
- fetchError  out  1  misaligned or out-of-range redirect (only with FETCH_ALIGN_CHECK_EN; otherwise tied 0)

## Operation
- States: RUN, HALTED, and ERROR when the macro is defined. Reset enters RUN.
- Priority per edge: reset > halt > stall > redirect > sequential.
- reset=0: PC=RESET_PC, instructionD=0, pcD=0, bubbleD=1, halted=0, fetchCount=0, fetchError=0, state RUN.
- RUN, halt=1:
  - Discard the instruction in F and set bubbleD=1.
  - Freeze PC and go to HALTED.
  - halt is honoured even when stall=1.
- RUN, stall=1: PC, instructionD, pcD, bubbleD and fetchCount all hold. A redirect in the same cycle is ignored; decode re-asserts it because the branch remains in D.
- RUN, redirect=1:
  - Latch the delay-slot instruction: instructionD=imemData, pcD=PC, bubbleD=0.
  - PC <= redirectTarget.
- RUN, otherwise: latch imemData and PC with bubbleD=0, and PC <= PC+4.
- fetchCount increments on every edge that writes bubbleD=0. It wraps modulo 2^32.
- PC arithmetic is 32-bit unsigned and wraps at 32'hFFFF_FFFC. Without the check macro, redirectTarget[1:0] are forced to 00.
- HALTED: all inputs except reset are ignored. bubbleD=1, halted=1, PC frozen. Leave only via reset.

## Timing
- imemAddr equals PC combinationally; imemData must settle in the same cycle.
- IF/ID latency is 1 cycle: the word present at edge t appears on instructionD after edge t.
- A redirect in cycle t applies the target at the next edge; the target is fetched in cycle t+1.
- The first valid instruction appears one cycle after reset deasserts. bubbleD=1 during reset and on that first cycle.
- halted rises at the edge that samples halt=1.
- Reset asserted mid-stall or mid-redirect wins unconditionally on that edge.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect is erroneous if redirectTarget[1:0]!=0 or (redirectTarget-RESET_PC)>>2 >= IMEM_WORDS.
  - On the edge that would accept an erroneous redirect: fetchError=1 (sticky), state ERROR, bubbleD=1, halted=1, PC holds the offending target.
  - A sequential PC running past the range behaves the same way.
- FETCH_ALIGN_CHECK_EN undefined:
  - No checks and no ERROR state; fetchError is constant 0.
  - Low target bits are masked to 00.

## Structure
- Shared constants package:
  - fetch state encoding (RUN, HALTED, ERROR)
  - default RESET_PC
  - PC increment of 4
  - bubble NOP word 32'h0
- Sub-module `ifid_register`: the IF/ID latch for instructionD, pcD and bubbleD, with load, hold (stall) and bubble-insert controls.
- The PC, FSM and counter stay in fetch_stage.

## Test plan
- Release reset with RESET_PC=0x3000 -> imemAddr 0x3000, then 0x3004 and 0x3008 on successive cycles; bubbleD=1 for the first cycle, then 0; fetchCount=2 after two valid latches.
- stall=1 for 3 cycles at PC=0x3008 -> imemAddr, instructionD, pcD and fetchCount unchanged; stall with redirect=1 to 0x3100 -> target ignored.
- redirect=1 to 0x3040 while PC=0x3010 -> instructionD gets the word at 0x3010 (delay slot, bubbleD=0); next imemAddr is 0x3040.
- halt=1 while stall=1 -> next cycle halted=1 and bubbleD=1; PC stays frozen for 10 cycles; reset returns to 0x3000.
- FETCH_ALIGN_CHECK_EN defined: redirect to 0x3042 -> fetchError=1, halted=1; redirect to 0x3000+4*IMEM_WORDS -> same response. Macro undefined: redirect to 0x3042 fetches 0x3040.
